// File: rtl/lab61_soc_leds_arbiter_if.sv
// Avalon-MM bus between the LED arbiter (master) and the 14-bit LED PIO s1 port (slave).
interface lab61_soc_leds_arbiter_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/lab61_soc_leds_arbiter.sv
// Round-robin arbiter sharing the LED PIO among NUM_REQ requesters: one write per grant, then a hold.
// Define LEDS_ARB_READBACK_EN to add a VERIFY cycle that reads the PIO back and sets a sticky err.
module lab61_soc_leds_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 14,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  lab61_soc_leds_arbiter_if.master  avm,
  output logic                      busy,
  output logic [2:0]                owner,
  output logic                      err
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef LEDS_ARB_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        rr_ptr;
  logic [DATA_W-1:0] data_q;
  logic [HCW-1:0]    hold_cnt;

  logic              grant_any;
  logic [IW-1:0]     win_sel;
  logic [IW-1:0]     arb_sel;
  int                arb_idx;
  logic [DATA_W-1:0] win_data;
  logic [NUM_REQ-1:0] ack_nxt;
  logic              cs_nxt;
  logic              wn_nxt;
  logic              unused_readdata;

  assign avm.avm_address = 2'b00;
  assign unused_readdata = ^avm.avm_readdata;

  // Search starts one past the last owner so the requester just served ranks lowest.
  always_comb begin
    grant_any = 1'b0;
    win_sel   = '0;
    arb_idx   = 0;
    arb_sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_idx = int'(rr_ptr) + k;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      arb_sel = IW'(arb_idx);
      if (!grant_any && req[arb_sel]) begin
        grant_any = 1'b1;
        win_sel   = arb_sel;
      end
    end
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_sel == IW'(k)) win_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the values the registered bus outputs take in that next state.
  always_comb begin
    state_nxt = state;
    ack_nxt   = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = WRITE;
          ack_nxt   = NUM_REQ'(1) << win_sel;
        end
      end
      WRITE:   state_nxt = READBACK ? VERIFY : ((HOLD_CYCLES > 0) ? HOLD : IDLE);
      VERIFY:  state_nxt = (HOLD_CYCLES > 0) ? HOLD : IDLE;
      HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    cs_nxt = (state_nxt == WRITE) || (state_nxt == VERIFY);
    wn_nxt = (state_nxt != WRITE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack                <= '0;
      avm.avm_chipselect <= 1'b0;
      avm.avm_write_n    <= 1'b1;
      avm.avm_writedata  <= '0;
      busy               <= 1'b0;
      owner              <= '0;
      rr_ptr             <= 3'(NUM_REQ - 1);
      hold_cnt           <= '0;
      data_q             <= '0;
    end else begin
      ack                <= ack_nxt;
      avm.avm_chipselect <= cs_nxt;
      avm.avm_write_n    <= wn_nxt;
      busy               <= (state_nxt != IDLE);
      if (state == IDLE && grant_any) begin
        data_q            <= win_data;
        owner             <= 3'(win_sel);
        avm.avm_writedata <= {{(32-DATA_W){1'b0}}, win_data};
      end
      if (state == WRITE) rr_ptr <= owner;
      // Loading HOLD_CYCLES-1 on entry gives exactly HOLD_CYCLES cycles of residency.
      if (state != HOLD && state_nxt == HOLD) begin
        hold_cnt <= HCW'(HOLD_CYCLES - 1);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

`ifdef LEDS_ARB_READBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (state == VERIFY && avm.avm_readdata[DATA_W-1:0] != data_q) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lab61_soc_leds_arbiter.sv
// Bench for lab61_soc_leds_arbiter: two instances (hold 4 and hold 0) checked every cycle
// against an occupancy-based reference model; honours LEDS_ARB_READBACK_EN.
module tb_lab61_soc_leds_arbiter;

  localparam int N  = 4;
  localparam int W  = 14;
  localparam int HA = 4;
  localparam int HB = 0;
`ifdef LEDS_ARB_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] ack_a, ack_b;
  logic         busy_a, busy_b, err_a, err_b;
  logic [2:0]   owner_a, owner_b;
  logic [W-1:0] pio_a, pio_b;
  logic         force_bad;

  lab61_soc_leds_arbiter_if bus_a ();
  lab61_soc_leds_arbiter_if bus_b ();

  lab61_soc_leds_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(HA)) dut_a (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack_a),
    .avm(bus_a.master), .busy(busy_a), .owner(owner_a), .err(err_a)
  );

  lab61_soc_leds_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(HB)) dut_b (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack_b),
    .avm(bus_b.master), .busy(busy_b), .owner(owner_b), .err(err_b)
  );

  // Minimal PIO slave: latches written patterns, readback can be forced to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pio_a <= '0;
      pio_b <= '0;
    end else begin
      if (bus_a.avm_chipselect && !bus_a.avm_write_n) pio_a <= bus_a.avm_writedata[W-1:0];
      if (bus_b.avm_chipselect && !bus_b.avm_write_n) pio_b <= bus_b.avm_writedata[W-1:0];
    end
  end
  assign bus_a.avm_readdata = force_bad ? 32'h0 : {{(32-W){1'b0}}, pio_a};
  assign bus_b.avm_readdata = force_bad ? 32'h0 : {{(32-W){1'b0}}, pio_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: each instance is "busy for rem more cycles" after a grant.
  int         hold_of[2] = '{HA, HB};
  int         m_rem[2];
  int         m_last[2];
  int         m_owner[2];
  logic [W-1:0] m_data[2];
  logic [N-1:0] m_ack[2];
  logic       m_wr[2];
  logic       m_cs[2];
  logic       m_err[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k]   = 0;
      m_last[k]  = N - 1;
      m_owner[k] = 0;
      m_data[k]  = '0;
      m_ack[k]   = '0;
      m_wr[k]    = 1'b0;
      m_cs[k]    = 1'b0;
      m_err[k]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int total;
      int w;
      bit found;
      total    = 1 + RB + hold_of[k];
      m_ack[k] = '0;
      m_wr[k]  = 1'b0;
      m_cs[k]  = 1'b0;
      if (m_rem[k] == 0) begin
        found = 1'b0;
        w     = 0;
        for (int s = 1; s <= N; s++) begin
          int i;
          i = (m_last[k] + s) % N;
          if (!found && req[i]) begin
            found = 1'b1;
            w     = i;
          end
        end
        if (found) begin
          m_owner[k] = w;
          m_last[k]  = w;
          m_data[k]  = req_data[w*W +: W];
          m_ack[k]   = N'(1) << w;
          m_wr[k]    = 1'b1;
          m_cs[k]    = 1'b1;
          m_rem[k]   = total;
        end
      end else begin
        if (RB == 1 && (total - m_rem[k]) == 1 && force_bad && m_data[k] != '0) m_err[k] = 1'b1;
        m_rem[k]--;
        if (RB == 1 && m_rem[k] > 0 && (total - m_rem[k]) == 1) m_cs[k] = 1'b1;
      end
    end
  endtask

  task automatic check_inst(input int k, input string nm, input logic [N-1:0] a, input logic cs,
                            input logic wn, input logic [1:0] ad, input logic [31:0] wd,
                            input logic b, input logic [2:0] own, input logic e);
    check({nm, "_ack"}, 32'(a), 32'(m_ack[k]));
    check({nm, "_chipselect"}, 32'(cs), 32'(m_cs[k]));
    check({nm, "_write_n"}, 32'(wn), 32'(!m_wr[k]));
    check({nm, "_address"}, 32'(ad), 32'h0);
    check({nm, "_busy"}, 32'(b), 32'(m_rem[k] != 0));
    check({nm, "_owner"}, 32'(own), 32'(m_owner[k]));
    check({nm, "_err"}, 32'(e), 32'(m_err[k]));
    if (m_wr[k]) check({nm, "_writedata"}, wd, {{(32-W){1'b0}}, m_data[k]});
  endtask

  task automatic check_output();
    check_inst(0, "a", ack_a, bus_a.avm_chipselect, bus_a.avm_write_n, bus_a.avm_address,
               bus_a.avm_writedata, busy_a, owner_a, err_a);
    check_inst(1, "b", ack_b, bus_b.avm_chipselect, bus_b.avm_write_n, bus_b.avm_address,
               bus_b.avm_writedata, busy_b, owner_b, err_b);
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_output();
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
  task automatic reset_pulse();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_output();
    check("a_writedata_rst", bus_a.avm_writedata, 32'h0);
    check("b_writedata_rst", bus_b.avm_writedata, 32'h0);
    #1 reset = 1'b0;
  endtask

  initial begin
    int first;
    int t0;
    int order[$];
    int times[$];
    int busy_cnt;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    force_bad = 1'b0;
    #2;
    model_reset();
    check_output();
    check("a_writedata_rst", bus_a.avm_writedata, 32'h0);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) apply_stimulus();

    $display("[TB] all requesters asserted");
    req      = 4'b1111;
    req_data = {14'h0444, 14'h0333, 14'h0222, 14'h0111};
    for (int i = 0; i < 5*(2+RB); i++) begin
      apply_stimulus();
      for (int j = 0; j < N; j++) begin
        if (ack_b[j]) begin
          order.push_back(j);
          times.push_back(cyc);
        end
      end
    end
    check("b_grant_count", 32'(order.size() >= 5), 32'h1);
    if (order.size() >= 5) begin
      for (int j = 0; j < 5; j++) check("b_grant_order", 32'(order[j]), 32'(exp_order[j]));
      for (int j = 1; j < 5; j++) check("b_grant_spacing", 32'(times[j] - times[j-1]), 32'(2 + RB));
    end

    req = '0;
    for (int i = 0; i < 12; i++) apply_stimulus();

    $display("[TB] single write with hold");
    req      = 4'b0001;
    req_data = {42'h0, 14'h2AAA};
    apply_stimulus();
    req      = '0;
    busy_cnt = int'(busy_a);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus();
      busy_cnt += int'(busy_a);
    end
    check("a_busy_cycles", 32'(busy_cnt), 32'(1 + RB + HA));
    check("a_pio_out", 32'(pio_a), 32'h2AAA);

    $display("[TB] request raised during hold");
    req = 4'b0001;
    apply_stimulus();
    t0    = cyc;
    first = -1;
    req   = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus();
      if (first < 0 && ack_a[2]) first = cyc;
    end
    check("a_hold_ack2_delay", 32'(first - t0), 32'(2 + RB + HA));

    req = '0;
    for (int i = 0; i < 12; i++) apply_stimulus();

    $display("[TB] reset during hold");
    req = 4'b0001;
    apply_stimulus();
    req = '0;
    apply_stimulus();
    apply_stimulus();
    req = 4'b0010;
    reset_pulse();
    apply_stimulus();
    check("a_owner_after_rst", 32'(owner_a), 32'h1);
    check("a_ack_after_rst", 32'(ack_a), 32'h2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      req_data = (N*W)'({$urandom(), $urandom()});
      apply_stimulus();
    end

`ifdef LEDS_ARB_READBACK_EN
    $display("[TB] readback mismatch");
    req = '0;
    for (int i = 0; i < 12; i++) apply_stimulus();
    reset_pulse();
    force_bad = 1'b1;
    req_data  = {42'h0, 14'h0001};
    req       = 4'b0001;
    for (int i = 0; i < 3; i++) apply_stimulus();
    req       = '0;
    force_bad = 1'b0;
    check("a_err_set", 32'(err_a), 32'h1);
    req = 4'b0110;
    for (int i = 0; i < 20; i++) apply_stimulus();
    check("a_err_sticky", 32'(err_a), 32'h1);
    req = '0;
    reset_pulse();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
